// File: rtl/coax_pkg.sv
// -----------------------------------------------------------------------------
// coax_pkg
// Shared types for the coax transceive sequencer: FSM state encoding, the
// transaction result codes reported on status, and the RX input mux helper.
// No ports (package).
// -----------------------------------------------------------------------------
package coax_pkg;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_TX_WAIT       = 3'd1,
        S_TX            = 3'd2,
        S_TURNAROUND    = 3'd3,
        S_RESPONSE_WAIT = 3'd4,
        S_RECEIVE       = 3'd5,
        S_FINISH        = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        STATUS_OK          = 3'd0,
        STATUS_NO_RESPONSE = 3'd1,
        STATUS_RX_ERROR    = 3'd2,
        STATUS_TX_FAULT    = 3'd3,
        STATUS_ABORTED     = 3'd4
    } status_e;

    // Line presented to the RX decoder: parked low while RX is disabled.
    function automatic logic rx_mux(input logic enable,
                                    input logic loopback,
                                    input logic tx_serial,
                                    input logic rx_serial);
        return enable & (loopback ? tx_serial : rx_serial);
    endfunction

endpackage

// File: rtl/coax_oneshot_timer.sv
// -----------------------------------------------------------------------------
// coax_oneshot_timer
// Loadable one-shot down-counter shared by the sequencer's timed phases.
// A load of value N makes expired_o high during the Nth cycle after the load
// edge, so a client that acts on expired_o leaves its state on the Nth clock.
// expired_o stays high until the next load.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   load_i     load value_i (takes priority over counting)
//   value_i    timeout length in clocks
//   expired_o  timeout reached
// -----------------------------------------------------------------------------
module coax_oneshot_timer #(
    parameter int TIMER_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic [TIMER_WIDTH-1:0] value_i,
    output logic                   expired_o
);

    localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic                   armed_q, armed_d;

    // N-1 is stored so that the zero check lands on the Nth clock.
    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        if (load_i) begin
            armed_d = 1'b1;
            count_d = (value_i == '0) ? '0 : value_i - ONE;
        end else if (armed_q && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    assign expired_o = armed_q && (count_q == '0);

endmodule

// File: rtl/coax_transceive_sequencer.sv
// -----------------------------------------------------------------------------
// coax_transceive_sequencer
// Runs one half-duplex coax transaction: kick the buffered TX, blank RX while
// the line turns around, open RX for the response window, wait for the end of
// the response and report a result code. Owns the RX input mux and the RX
// flush pulse.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   start            one-clock pulse, begin transaction (ignored while busy)
//   expect_response  sampled with start; 0 = finish after TX
//   loopback         sampled with start; RX fed from tx_serial
//   abort            one-clock pulse, cancel transaction
//   tx_start         one-clock pulse to coax_buffered_tx
//   tx_active        TX transmitting
//   tx_serial        TX line (loopback source)
//   rx_serial        synchronised coax RX line
//   rx_line          registered line into coax_buffered_rx
//   rx_reset         one-clock pulse, flush RX FIFO/decoder
//   rx_active        RX receiving
//   rx_error         RX error level
//   busy             state != IDLE
//   done             one-clock pulse at transaction end
//   status           result code, held until the next accepted start
//
// state           | meaning
// ----------------+------------------------------------------------------
// S_IDLE          | waiting for start
// S_TX_WAIT       | tx_start issued, waiting for tx_active (TX start timeout)
// S_TX            | transmitting; RX open only in loopback
// S_TURNAROUND    | RX blanked while the line rings down
// S_RESPONSE_WAIT | RX open, waiting for rx_active (response timeout)
// S_RECEIVE       | response in progress, collecting rx_error
// S_FINISH        | status final; done pulses on the way back to idle
// -----------------------------------------------------------------------------
module coax_transceive_sequencer
    import coax_pkg::*;
#(
    parameter int TURNAROUND_CLOCKS = 32,
    parameter int RESPONSE_TIMEOUT  = 224,
    parameter int TX_START_TIMEOUT  = 64,
    parameter int TIMER_WIDTH       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       expect_response,
    input  logic       loopback,
    input  logic       abort,
    output logic       tx_start,
    input  logic       tx_active,
    input  logic       tx_serial,
    input  logic       rx_serial,
    output logic       rx_line,
    output logic       rx_reset,
    input  logic       rx_active,
    input  logic       rx_error,
    output logic       busy,
    output logic       done,
    output logic [2:0] status
);

    localparam logic [TIMER_WIDTH-1:0] TURNAROUND_LOAD = TIMER_WIDTH'(TURNAROUND_CLOCKS);
    localparam logic [TIMER_WIDTH-1:0] RESPONSE_LOAD   = TIMER_WIDTH'(RESPONSE_TIMEOUT);
    localparam logic [TIMER_WIDTH-1:0] TX_START_LOAD   = TIMER_WIDTH'(TX_START_TIMEOUT);

    state_e  state_q, state_d;
    status_e status_q, status_d;

    logic expect_q, expect_d;
    logic loopback_q, loopback_d;
    logic seen_q, seen_d;
    logic rx_err_q, rx_err_d;
    logic rx_enable_q, rx_enable_d;
    logic rx_active_prev_q;
    logic tx_start_q, tx_start_d;
    logic rx_reset_q, rx_reset_d;
    logic done_q, done_d;
    logic rx_line_q, rx_line_d;

    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   timer_expired;
    logic                   rx_rise;

    coax_oneshot_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (timer_load),
        .value_i   (timer_value),
        .expired_o (timer_expired)
    );

    assign rx_rise = rx_active && !rx_active_prev_q;

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        expect_d    = expect_q;
        loopback_d  = loopback_q;
        seen_d      = seen_q;
        rx_err_d    = rx_err_q;
        rx_enable_d = rx_enable_q;
        tx_start_d  = 1'b0;
        rx_reset_d  = 1'b0;
        done_d      = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;

        case (state_q)
            S_IDLE: begin
                rx_enable_d = 1'b0;
                if (start) begin
                    expect_d    = expect_response;
                    loopback_d  = loopback;
                    status_d    = STATUS_OK;
                    seen_d      = 1'b0;
                    rx_err_d    = 1'b0;
                    tx_start_d  = 1'b1;
                    rx_reset_d  = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = TX_START_LOAD;
                    state_d     = S_TX_WAIT;
                end
            end

            S_TX_WAIT: begin
                if (tx_active) begin
                    rx_enable_d = loopback_q;
                    state_d     = S_TX;
                end else if (timer_expired) begin
                    status_d = STATUS_TX_FAULT;
                    state_d  = S_FINISH;
                end
            end

            S_TX: begin
                rx_enable_d = loopback_q;
                if (loopback_q && rx_rise) begin
                    seen_d = 1'b1;
                end
                if (!tx_active) begin
                    if (loopback_q) begin
                        // A response already under way (including one that
                        // starts on this very clock) is followed to its end.
                        if (rx_active) begin
                            state_d = S_RECEIVE;
                        end else begin
                            status_d = seen_q ? STATUS_OK : STATUS_NO_RESPONSE;
                            state_d  = S_FINISH;
                        end
                    end else if (!expect_q) begin
                        status_d    = STATUS_OK;
                        rx_enable_d = 1'b0;
                        state_d     = S_FINISH;
                    end else begin
                        rx_enable_d = 1'b0;
                        timer_load  = 1'b1;
                        timer_value = TURNAROUND_LOAD;
                        state_d     = S_TURNAROUND;
                    end
                end
            end

            S_TURNAROUND: begin
                rx_enable_d = 1'b0;
                if (timer_expired) begin
                    rx_enable_d = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = RESPONSE_LOAD;
                    state_d     = S_RESPONSE_WAIT;
                end
            end

            S_RESPONSE_WAIT: begin
                if (rx_active) begin
                    state_d = S_RECEIVE;
                end else if (timer_expired) begin
                    status_d    = STATUS_NO_RESPONSE;
                    rx_enable_d = 1'b0;
                    state_d     = S_FINISH;
                end
            end

            S_RECEIVE: begin
                rx_err_d = rx_err_q || rx_error;
                if (!rx_active) begin
                    status_d = (rx_err_q || rx_error) ? STATUS_RX_ERROR : STATUS_OK;
                    state_d  = S_FINISH;
                end
            end

            S_FINISH: begin
                rx_enable_d = 1'b0;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                rx_enable_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        // Abort overrides every other decision, including a coincident expiry.
        if (abort && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
            status_d    = STATUS_ABORTED;
            rx_enable_d = 1'b0;
            rx_reset_d  = 1'b1;
            timer_load  = 1'b0;
            state_d     = S_FINISH;
        end

        rx_line_d = rx_mux(rx_enable_d, loopback_d, tx_serial, rx_serial);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            status_q         <= STATUS_OK;
            expect_q         <= 1'b0;
            loopback_q       <= 1'b0;
            seen_q           <= 1'b0;
            rx_err_q         <= 1'b0;
            rx_enable_q      <= 1'b0;
            rx_active_prev_q <= 1'b0;
            tx_start_q       <= 1'b0;
            rx_reset_q       <= 1'b0;
            done_q           <= 1'b0;
            rx_line_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            status_q         <= status_d;
            expect_q         <= expect_d;
            loopback_q       <= loopback_d;
            seen_q           <= seen_d;
            rx_err_q         <= rx_err_d;
            rx_enable_q      <= rx_enable_d;
            rx_active_prev_q <= rx_active;
            tx_start_q       <= tx_start_d;
            rx_reset_q       <= rx_reset_d;
            done_q           <= done_d;
            rx_line_q        <= rx_line_d;
        end
    end

    assign tx_start = tx_start_q;
    assign rx_reset = rx_reset_q;
    assign done     = done_q;
    assign rx_line  = rx_line_q;
    assign busy     = (state_q != S_IDLE);
    assign status   = status_q;

endmodule
